// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizing for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_BURST_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Read tag carried alongside the RAM access until its data returns
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side request/response bundle; one instance per requester.
interface ram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = ram_port_arbiter_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ram_port_arbiter_pkg::DEF_ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_grant2.sv
// Combinational two-way grant: round-robin from idle, burst-limited retention while owned.
module rr_grant2
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  state_t           state,
  input  logic [CNT_W-1:0] beat_cnt,
  input  req_id_t          last_id,
  input  logic             a_valid,
  input  logic             b_valid,
  output logic             gnt_a_c,
  output logic             gnt_b_c
);

  logic under_burst;

  assign under_burst = beat_cnt < CNT_W'(BURST_LEN);

  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    case (state)
      OWN_A: begin
        if (a_valid && (under_burst || !b_valid)) gnt_a_c = 1'b1;
        else if (b_valid)                         gnt_b_c = 1'b1;
        else if (a_valid)                         gnt_a_c = 1'b1;
      end
      OWN_B: begin
        if (b_valid && (under_burst || !a_valid)) gnt_b_c = 1'b1;
        else if (a_valid)                         gnt_a_c = 1'b1;
        else if (b_valid)                         gnt_b_c = 1'b1;
      end
      default: begin
        // Tie goes to whoever was not served last
        if (a_valid && b_valid) begin
          if (last_id == REQ_B) gnt_a_c = 1'b1;
          else                  gnt_b_c = 1'b1;
        end else begin
          gnt_a_c = a_valid;
          gnt_b_c = b_valid;
        end
      end
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto one synchronous RAM port and routes read data back by tag.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_arbiter_if.slave     a,
  ram_port_arbiter_if.slave     b,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  state_t                state;
  logic [CNT_W-1:0]      beat_cnt;
  req_id_t               last_id;
  tag_t                  tag0;
  tag_t                  tag1;
  logic                  gnt_a_c;
  logic                  gnt_b_c;
  logic                  xfer_a;
  logic                  xfer_b;
  logic                  rd_issue;
  logic                  a_hit;
  logic                  b_hit;
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;

  rr_grant2 #(
    .CNT_W     (CNT_W),
    .BURST_LEN (BURST_LEN)
  ) u_grant (
    .state    (state),
    .beat_cnt (beat_cnt),
    .last_id  (last_id),
    .a_valid  (a.req_valid),
    .b_valid  (b.req_valid),
    .gnt_a_c  (gnt_a_c),
    .gnt_b_c  (gnt_b_c)
  );

  // Nothing is accepted while reset is held
  assign xfer_a   = gnt_a_c & ~reset;
  assign xfer_b   = gnt_b_c & ~reset;
  assign rd_issue = (xfer_a & ~a.req_we) | (xfer_b & ~b.req_we);

  assign a.req_ready = xfer_a;
  assign b.req_ready = xfer_b;

  // Tag reaches stage 1 in the same cycle the RAM presents read data
  assign a_hit = tag1.valid & (tag1.id == REQ_A);
  assign b_hit = tag1.valid & (tag1.id == REQ_B);

  assign a.rsp_valid = a_hit;
  assign b.rsp_valid = b_hit;
  assign a.rsp_rdata = a_hit ? ram_dout : a_rdata_q;
  assign b.rsp_rdata = b_hit ? ram_dout : b_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      last_id   <= REQ_B;
      tag0      <= '0;
      tag1      <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (xfer_a) begin
        state    <= OWN_A;
        last_id  <= REQ_A;
        beat_cnt <= (state != OWN_A)               ? CNT_W'(1) :
                    (beat_cnt == CNT_W'(BURST_LEN)) ? beat_cnt  : beat_cnt + CNT_W'(1);
        ram_addr <= a.req_addr;
        ram_din  <= a.req_wdata;
      end else if (xfer_b) begin
        state    <= OWN_B;
        last_id  <= REQ_B;
        beat_cnt <= (state != OWN_B)               ? CNT_W'(1) :
                    (beat_cnt == CNT_W'(BURST_LEN)) ? beat_cnt  : beat_cnt + CNT_W'(1);
        ram_addr <= b.req_addr;
        ram_din  <= b.req_wdata;
      end else begin
        state    <= IDLE;
      end

      ram_we <= (xfer_a & a.req_we) | (xfer_b & b.req_we);
      ram_re <= rd_issue;

      tag0.valid <= rd_issue;
      tag0.id    <= xfer_b ? REQ_B : REQ_A;
      tag1       <= tag0;

      if (a_hit) a_rdata_q <= ram_dout;
      if (b_hit) b_rdata_q <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: grant vector table, RAM model, and an in-order read scoreboard.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a_if),
    .b        (b_if),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic rst_d;

  // Synchronous RAM model: data appears the cycle after ram_re
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    req_id_t       id;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;

  // Scoreboard: expected read data from a shadow of accepted writes
  always @(negedge clk) begin
    if (cyc == 1) begin
      for (int i = 0; i < 16; i++) shadow[i] = '0;
    end
    if (rst_d === 1'b1) begin
      sb.delete();
      last_a = '0;
      last_b = '0;
    end
    if (sb.size() > 0 && cyc > sb[0].acc + 2) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: no response, accepted cycle %0d, now %0d", sb[0].acc, cyc);
      void'(sb.pop_front());
    end
    if (a_if.rsp_valid === 1'b1 || b_if.rsp_valid === 1'b1) begin
      check("rsp_one_hot", 32'(a_if.rsp_valid & b_if.rsp_valid), 32'(0));
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: a=%0b b=%0b, expected none", a_if.rsp_valid, b_if.rsp_valid);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(b_if.rsp_valid), 32'(e.id == REQ_B));
        check("rsp_latency", 32'(cyc - e.acc), 32'(2));
        if (e.id == REQ_A) begin
          check("rsp_a_data", 32'(a_if.rsp_rdata), 32'(e.data));
          last_a = e.data;
        end else begin
          check("rsp_b_data", 32'(b_if.rsp_rdata), 32'(e.data));
          last_b = e.data;
        end
      end
    end
    if (a_if.rsp_valid === 1'b0) check("a_rdata_hold", 32'(a_if.rsp_rdata), 32'(last_a));
    if (b_if.rsp_valid === 1'b0) check("b_rdata_hold", 32'(b_if.rsp_rdata), 32'(last_b));
    if (a_if.req_valid === 1'b1 && a_if.req_ready === 1'b1) begin
      if (a_if.req_we) shadow[a_if.req_addr] = a_if.req_wdata;
      else begin
        e.id = REQ_A; e.data = shadow[a_if.req_addr]; e.acc = cyc;
        sb.push_back(e);
      end
    end
    if (b_if.req_valid === 1'b1 && b_if.req_ready === 1'b1) begin
      if (b_if.req_we) shadow[b_if.req_addr] = b_if.req_wdata;
      else begin
        e.id = REQ_B; e.data = shadow[b_if.req_addr]; e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic bv, input logic bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    a_if.req_valid = av; a_if.req_we = awe; a_if.req_addr = aad; a_if.req_wdata = awd;
    b_if.req_valid = bv; b_if.req_we = bwe; b_if.req_addr = bad; b_if.req_wdata = bwd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_ready(input string name, input logic exp_a, input logic exp_b);
    #1;
    check({name, "_a_ready"}, 32'(a_if.req_ready), 32'(exp_a));
    check({name, "_b_ready"}, 32'(b_if.req_ready), 32'(exp_b));
  endtask

  typedef struct {
    logic av;
    logic bv;
    logic exp_a;
    logic exp_b;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Grant sequence from reset; all beats are writes to address = row index
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    idle();
    tick();
    tick();
    check("rst_ram_we", 32'(ram_we), 32'(0));
    check("rst_ram_re", 32'(ram_re), 32'(0));
    check("rst_ram_addr", 32'(ram_addr), 32'(0));
    check("rst_ram_din", 32'(ram_din), 32'(0));
    check("rst_a_rsp_valid", 32'(a_if.rsp_valid), 32'(0));
    check("rst_b_rsp_rdata", 32'(b_if.rsp_rdata), 32'(0));
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    check_ready("rst", 1'b0, 1'b0);
    idle();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].av, 1'b1, AW'(i), DW'(i + 5), vecs[i].bv, 1'b1, AW'(i), DW'(i + 9));
      check_ready($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
      tick();
    end
    idle();
    tick();

    // A alone writes the whole array
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, AW'(i), DW'(i), 1'b0, 1'b0, '0, '0);
      check_ready("fill", 1'b1, 1'b0);
      tick();
      check("fill_ram_we", 32'(ram_we), 32'(1));
      check("fill_ram_addr", 32'(ram_addr), 32'(i));
      check("fill_ram_din", 32'(ram_din), 32'(i));
    end
    idle();
    tick();
    check("fill_idle_we", 32'(ram_we), 32'(0));
    check("fill_addr_hold", 32'(ram_addr), 32'(15));

    // Both requesters stream reads from reset: 4-beat alternating bursts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 8), '0);
      check_ready($sformatf("rr%0d", i), ((i / 4) % 2) == 0, ((i / 4) % 2) != 0);
      tick();
    end
    idle();
    repeat (3) tick();

    // Write then immediate read of the same address
    drive(1'b1, 1'b1, 4'd3, 4'h9, 1'b0, 1'b0, '0, '0);
    check_ready("wr3", 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0);
    check_ready("rd3", 1'b1, 1'b0);
    tick();
    idle();
    check("rd3_early", 32'(a_if.rsp_valid), 32'(0));
    tick();
    check("rd3_valid", 32'(a_if.rsp_valid), 32'(1));
    check("rd3_data", 32'(a_if.rsp_rdata), 32'(9));
    check("rd3_b_quiet", 32'(b_if.rsp_valid), 32'(0));
    tick();
    check("rd3_pulse", 32'(a_if.rsp_valid), 32'(0));
    check("rd3_hold", 32'(a_if.rsp_rdata), 32'(9));

    // Alternating single reads A then B
    drive(1'b1, 1'b0, 4'd1, '0, 1'b0, 1'b0, '0, '0);
    check_ready("alt_a", 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd2, '0);
    check_ready("alt_b", 1'b0, 1'b1);
    tick();
    idle();
    check("alt_a_valid", 32'(a_if.rsp_valid), 32'(1));
    check("alt_a_data", 32'(a_if.rsp_rdata), 32'(1));
    tick();
    check("alt_b_valid", 32'(b_if.rsp_valid), 32'(1));
    check("alt_b_data", 32'(b_if.rsp_rdata), 32'(2));
    check("alt_a_done", 32'(a_if.rsp_valid), 32'(0));
    tick();

    // Reset one cycle after a read accept drops the response
    drive(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0);
    check_ready("mid_rd", 1'b1, 1'b0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    check("mid_a_rsp", 32'(a_if.rsp_valid), 32'(0));
    check("mid_b_rsp", 32'(b_if.rsp_valid), 32'(0));
    check("mid_ram_we", 32'(ram_we), 32'(0));
    check("mid_ram_re", 32'(ram_re), 32'(0));
    check("mid_ram_addr", 32'(ram_addr), 32'(0));
    check("mid_ram_din", 32'(ram_din), 32'(0));
    check("mid_a_rdata", 32'(a_if.rsp_rdata), 32'(0));
    drive(1'b1, 1'b0, 4'd6, '0, 1'b1, 1'b0, 4'd7, '0);
    check_ready("mid_in_rst", 1'b0, 1'b0);
    reset = 1'b0;
    check_ready("post_rst", 1'b1, 1'b0);
    tick();
    idle();
    repeat (3) tick();

    // A streams alone past the burst limit, then B is served at once
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
      check_ready($sformatf("stream%0d", i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 4'd10, '0, 1'b1, 1'b0, 4'd11, '0);
    check_ready("stream_handoff", 1'b0, 1'b1);
    tick();
    idle();
    repeat (4) tick();

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 4: RAM and requester data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4: RAM address width; depth is 2**ADDR_WIDTH.
REQ-003 Parameter BURST_LEN, default 4: maximum consecutive accepted beats per owner while the other requester waits.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 a_req_valid / b_req_valid  in  1  request present from requester A / B.
REQ-007 a_req_ready / b_req_ready  out  1  request accepted this cycle (combinational grant).
REQ-008 a_req_we / b_req_we  in  1  1 = write, 0 = read.
REQ-009 a_req_addr / b_req_addr  in  ADDR_WIDTH  target address.
REQ-010 a_req_wdata / b_req_wdata  in  DATA_WIDTH  write data.
REQ-011 a_rsp_valid / b_rsp_valid  out  1  read data valid for A / B, one-cycle pulse per read.
REQ-012 a_rsp_rdata / b_rsp_rdata  out  DATA_WIDTH  read data, meaningful only with matching rsp_valid.
REQ-013 ram_we, ram_re  out  1  registered RAM port write and read enables.
REQ-014 ram_addr  out  ADDR_WIDTH; ram_din  out  DATA_WIDTH: registered RAM port address and write data.
REQ-015 ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re is high.

Function
REQ-016 A transfer occurs on a requester when its req_valid and req_ready are both high in the same cycle; at most one transfer occurs per cycle.
REQ-017 FSM states: IDLE, OWN_A, OWN_B; next state is OWN_A/OWN_B when A/B transfers this cycle, else IDLE.
REQ-018 Grant in IDLE: the single valid requester wins; if both are valid, the requester not served last wins (rr pointer); after reset the pointer favours A.
REQ-019 Grant in OWN_x: x retains if x valid and (beat_cnt < BURST_LEN or other not valid); else the other wins if valid; else x wins if valid; else none.
REQ-020 beat_cnt is set to 1 on a transfer by a new owner and increments on each transfer by the same owner, saturating at BURST_LEN.
REQ-021 The rr pointer updates to the transferring requester on every transfer.
REQ-022 The cycle after a transfer, ram_we = req_we, ram_re = !req_we, ram_addr/ram_din = the granted requester's values; with no transfer, ram_we = ram_re = 0 and addr/din hold their previous values.
REQ-023 Read latency: the rsp_valid of the issuing requester pulses exactly 2 cycles after the accepting cycle, with rsp_rdata = ram_dout in that cycle.
REQ-024 A two-stage {valid, id} tag pipeline tracks reads; back-to-back reads from either requester produce back-to-back responses in issue order.
REQ-025 Writes produce no response; a read following a write to the same address on the next cycle returns the new data (RAM write-before-read ordering is preserved by issue order).
REQ-026 req_ready is never high for a requester whose req_valid is low; both readies are never high together.
REQ-027 rsp_rdata holds its last value when rsp_valid is low.

Reset
REQ-028 While reset is high at a rising edge: state IDLE, beat_cnt 0, rr pointer favours A, tag pipeline cleared, and ram_we, ram_re, ram_addr, ram_din, rsp_valid and rsp_rdata all 0.
REQ-029 Reset asserted mid-operation drops in-flight reads with no rsp_valid issued; req_ready is 0 during reset.

Structure
REQ-030 A shared package holds the state enum (IDLE, OWN_A, OWN_B), the requester-id type (A = 0, B = 1), and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-031 One sub-module, rr_grant2, implements the combinational grant of REQ-018/019 from state, beat_cnt, pointer and valids; the FSM, counter, RAM registers and tag pipeline live in ram_port_arbiter.

Verification
REQ-032 A writes addr 0..15 with data = addr, B idle -> 16 consecutive accepts, ram_we high 16 cycles, ram_addr 0..15.
REQ-033 Both valid from reset, with continuous reads -> A gets 4 beats, B gets 4, A gets 4, and so on; readies are never both high.
REQ-034 A reads addr 3 after a write of 0x9 -> a_rsp_valid pulses exactly 2 cycles after acceptance with a_rsp_rdata = 0x9; b_rsp_valid stays 0.
REQ-035 Alternating single reads A(addr 1), B(addr 2) on consecutive cycles -> responses on consecutive cycles in order A then B, with the correct data.
REQ-036 Reset asserted 1 cycle after a read accept -> no rsp_valid, all outputs 0 next cycle, and the first post-reset both-valid cycle grants A.
REQ-037 A alone streams 10 beats with b_req_valid low -> A is never pre-empted; beat_cnt saturates at 4 without a grant gap.
